// File: rtl/osecpu_core_p_if.sv
// Instruction-memory fetch port of the OSECPU core: req/ack handshake with
// same-cycle read data.
interface osecpu_core_p_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/osecpu_core_p.sv
// Multi-cycle OSECPU execution core: fetches over a req/ack port, executes
// against an integer register file, and exposes DR, PC, halt and error status.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for run; no fetch outstanding
// FETCH   | imem_req high at pc; waits for imem_ack, then latches the word
// EXEC    | decodes the latched word, writes R[] or dr, or stops the core
// HALT    | stopped on END or illegal instruction; only reset leaves
module osecpu_core_p #(
    parameter int DATA_W   = 32,
    parameter int NUM_IREG = 64,
    parameter int ADDR_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    osecpu_core_p_if.master       imem,
    output logic [DATA_W-1:0]     dr,
    output logic [ADDR_W-1:0]     pc,
    output logic                  halted,
    output logic                  err,
    output logic [31:0]           retired
);
    localparam int IDX_W = (NUM_IREG > 1) ? $clog2(NUM_IREG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t            state;
    logic              req_q;
    logic [31:0]       ir;
    logic [DATA_W-1:0] rf [NUM_IREG];

    logic [7:0]        op;
    logic [5:0]        ra;
    logic [5:0]        rb;
    logic [5:0]        rc;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] ra_v;
    logic [DATA_W-1:0] rb_v;
    logic [DATA_W-1:0] rc_v;

    logic              legal;
    logic              wr_en;
    logic              dr_en;
    logic              is_end;
    logic [DATA_W-1:0] wr_val;

    function automatic logic idx_ok(input logic [5:0] idx);
        return 32'(idx) < 32'(NUM_IREG);
    endfunction

    assign op      = ir[31:24];
    assign ra      = ir[23:18];
    assign rb      = ir[17:12];
    assign rc      = ir[11:6];
    assign imm_ext = DATA_W'($signed(ir[15:0]));

    // Reads may index past NUM_IREG only for instructions decoded as illegal,
    // and those never write, so the read value is don't-care there.
    assign ra_v = rf[ra[IDX_W-1:0]];
    assign rb_v = rf[rb[IDX_W-1:0]];
    assign rc_v = rf[rc[IDX_W-1:0]];

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    always_comb begin
        legal  = 1'b1;
        wr_en  = 1'b0;
        dr_en  = 1'b0;
        is_end = 1'b0;
        wr_val = '0;
        case (op)
            8'h02: begin
                legal  = idx_ok(ra);
                wr_en  = 1'b1;
                wr_val = imm_ext;
            end
            8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h20: begin
                legal = idx_ok(ra) && idx_ok(rb) && idx_ok(rc);
                wr_en = 1'b1;
                case (op)
                    8'h10:   wr_val = rb_v | rc_v;
                    8'h11:   wr_val = rb_v ^ rc_v;
                    8'h12:   wr_val = rb_v & rc_v;
                    8'h14:   wr_val = rb_v + rc_v;
                    8'h15:   wr_val = rb_v - rc_v;
                    default: wr_val = (rb_v == rc_v) ? '1 : '0;
                endcase
            end
            8'hD2: begin
                legal  = idx_ok(ra) && idx_ok(rb);
                wr_en  = 1'b1;
                wr_val = rb_v;
            end
            8'hD3: begin
                legal = idx_ok(ra);
                dr_en = 1'b1;
            end
            8'hF0: is_end = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            ir      <= '0;
            pc      <= '0;
            dr      <= '0;
            halted  <= 1'b0;
            err     <= 1'b0;
            retired <= '0;
            for (int i = 0; i < NUM_IREG; i++) rf[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_FETCH;
                        req_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        ir    <= imem.imem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        req_q <= 1'b0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!legal) begin
                        err    <= 1'b1;
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (is_end) begin
                        retired <= retired + 32'd1;
                        halted  <= 1'b1;
                        state   <= ST_HALT;
                    end else begin
                        if (wr_en) rf[ra[IDX_W-1:0]] <= wr_val;
                        if (dr_en) dr <= ra_v;
                        retired <= retired + 32'd1;
                        req_q   <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_osecpu_core_p.sv
// Bench for osecpu_core_p: a 32-bit/64-register core and a 16-bit/8-register
// core with a 4-bit PC, each fed from a wait-state instruction memory.
module tb_osecpu_core_p;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_a = 1'b0;
    logic        run_b = 1'b0;

    logic [31:0] dr_a;
    logic [15:0] pc_a;
    logic        halted_a, err_a;
    logic [31:0] ret_a;
    logic [15:0] dr_b;
    logic [3:0]  pc_b;
    logic        halted_b, err_b;
    logic [31:0] ret_b;

    osecpu_core_p_if #(.ADDR_W(16)) ifa ();
    osecpu_core_p_if #(.ADDR_W(4))  ifb ();

    osecpu_core_p #(.DATA_W(32), .NUM_IREG(64), .ADDR_W(16)) u_a (
        .clk(clk), .reset(reset), .run(run_a), .imem(ifa),
        .dr(dr_a), .pc(pc_a), .halted(halted_a), .err(err_a), .retired(ret_a)
    );

    osecpu_core_p #(.DATA_W(16), .NUM_IREG(8), .ADDR_W(4)) u_b (
        .clk(clk), .reset(reset), .run(run_b), .imem(ifb),
        .dr(dr_b), .pc(pc_b), .halted(halted_b), .err(err_b), .retired(ret_b)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prog [64];
    int          wait_cycles = 0;
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];

    int          cnt_a = 0, cnt_b = 0;
    logic        prev_req_a = 1'b0, prev_req_b = 1'b0;
    logic [15:0] prev_addr_a = '0;
    logic [3:0]  prev_addr_b = '0;
    int          addr_moved = 0;

    // Instruction memory: ack after wait_cycles req-high cycles, data same cycle.
    always @(negedge clk) begin
        if (ifa.imem_req) begin
            if (prev_req_a && ifa.imem_addr !== prev_addr_a) addr_moved++;
            if (cnt_a >= wait_cycles) begin
                ifa.imem_ack   = 1'b1;
                ifa.imem_rdata = prog[6'(ifa.imem_addr)];
                cnt_a          = 0;
            end else begin
                ifa.imem_ack   = 1'b0;
                ifa.imem_rdata = 32'hDEAD_BEEF;
                cnt_a++;
            end
        end else begin
            ifa.imem_ack   = 1'b0;
            ifa.imem_rdata = 32'hDEAD_BEEF;
            cnt_a          = 0;
        end
        prev_req_a  = ifa.imem_req;
        prev_addr_a = ifa.imem_addr;
    end

    always @(negedge clk) begin
        if (ifb.imem_req) begin
            if (prev_req_b && ifb.imem_addr !== prev_addr_b) addr_moved++;
            if (cnt_b >= wait_cycles) begin
                ifb.imem_ack   = 1'b1;
                ifb.imem_rdata = prog[6'(ifb.imem_addr)];
                cnt_b          = 0;
            end else begin
                ifb.imem_ack   = 1'b0;
                ifb.imem_rdata = 32'hDEAD_BEEF;
                cnt_b++;
            end
        end else begin
            ifb.imem_ack   = 1'b0;
            ifb.imem_rdata = 32'hDEAD_BEEF;
            cnt_b          = 0;
        end
        prev_req_b  = ifb.imem_req;
        prev_addr_b = ifb.imem_addr;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] limm(input int ra, input logic [15:0] imm);
        return {8'h02, 6'(ra), 2'b00, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [7:0] op, input int ra, input int rb, input int rc);
        return {op, 6'(ra), 6'(rb), 6'(rc), 6'd0};
    endfunction

    function automatic logic [31:0] cpdr(input int ra);
        return {8'hD3, 6'(ra), 18'd0};
    endfunction

    localparam logic [31:0] I_END = 32'hF000_0000;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        run_a = 1'b0;
        run_b = 1'b0;
        wait_cycles = 0;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 64; i++) prog[i] = I_END;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        addr_moved = 0;
    endtask

    // Pulses run on one core and records every dr change until halted.
    task automatic run_core(input bit sel, input int max, output int cyc, output bit tmo);
        logic [63:0] last, cur;
        @(negedge clk);
        if (sel) run_b = 1'b1; else run_a = 1'b1;
        @(posedge clk);
        #1;
        run_a = 1'b0;
        run_b = 1'b0;
        last = sel ? 64'(dr_b) : 64'(dr_a);
        cyc = 0;
        tmo = 1'b0;
        while (!(sel ? halted_b : halted_a)) begin
            if (cyc >= max) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            cur = sel ? 64'(dr_b) : 64'(dr_a);
            if (cur !== last) obs_q.push_back(cur);
            last = cur;
        end
    endtask

    task automatic load_logic_prog();
        prog[0]  = limm(1, 16'h1234);
        prog[1]  = limm(2, 16'h00FF);
        prog[2]  = rr(8'h10, 3, 1, 2);
        prog[3]  = rr(8'h11, 4, 1, 2);
        prog[4]  = rr(8'h12, 5, 1, 2);
        prog[5]  = rr(8'h20, 6, 1, 1);
        prog[6]  = rr(8'h20, 7, 1, 2);
        prog[7]  = rr(8'hD2, 8, 5, 0);
        prog[8]  = rr(8'h14, 1, 1, 1);
        prog[9]  = cpdr(3);
        prog[10] = cpdr(4);
        prog[11] = cpdr(5);
        prog[12] = cpdr(6);
        prog[13] = cpdr(7);
        prog[14] = cpdr(8);
        prog[15] = cpdr(1);
        prog[16] = I_END;
        exp_q.push_back(64'h12FF);
        exp_q.push_back(64'h12CB);
        exp_q.push_back(64'h0034);
        exp_q.push_back(64'hFFFF_FFFF);
        exp_q.push_back(64'h0000);
        exp_q.push_back(64'h0034);
        exp_q.push_back(64'h2468);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (pc_a !== 16'd0)  begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc_a); end
        n_cmp++; if (dr_a !== 32'd0)  begin n_bad++; $display("FAIL reset_dr: got %h want 0", dr_a); end
        n_cmp++; if (ret_a !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", ret_a); end
        n_cmp++; if ({halted_a, err_a, halted_b, err_b} !== 4'b0) begin n_bad++; $display("FAIL reset_status: got %b want 0000", {halted_a, err_a, halted_b, err_b}); end
        n_cmp++; if (ifa.imem_req !== 1'b0 || ifa.imem_addr !== 16'd0) begin n_bad++; $display("FAIL reset_imem: got req=%b addr=%h want 0/0", ifa.imem_req, ifa.imem_addr); end
        n_cmp++; if (u_a.rf[5] !== 32'd0) begin n_bad++; $display("FAIL reset_rf: got %h want 0", u_a.rf[5]); end
    endtask

    task automatic test_limm_cpdr();
        int cyc; bit tmo; logic [63:0] e, o;
        do_reset();
        prog[0] = limm(1, 16'h8000);
        prog[1] = cpdr(1);
        prog[2] = I_END;
        exp_q.push_back(64'hFFFF_8000);
        run_core(1'b0, 200, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL limm_timeout: got timeout want halt"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL limm_dr: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL limm_dr: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL limm_extra_dr: got %0d extra want 0", obs_q.size()); end
        n_cmp++; if (ret_a !== 32'd3) begin n_bad++; $display("FAIL limm_retired: got %0d want 3", ret_a); end
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL limm_cycles: got %0d want 6", cyc); end
    endtask

    task automatic test_logic_ops();
        int cyc; bit tmo; logic [63:0] e, o;
        do_reset();
        load_logic_prog();
        run_core(1'b0, 400, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL logic_timeout: got timeout want halt"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL logic_dr: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL logic_dr: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL logic_extra_dr: got %0d extra want 0", obs_q.size()); end
        n_cmp++; if (ret_a !== 32'd17 || pc_a !== 16'd17) begin n_bad++; $display("FAIL logic_count: got retired=%0d pc=%0d want 17/17", ret_a, pc_a); end
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL logic_cycles: got %0d want 34", cyc); end
    endtask

    task automatic test_wait_states();
        int cyc; bit tmo; logic [63:0] e, o;
        do_reset();
        wait_cycles = 3;
        load_logic_prog();
        run_core(1'b0, 400, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL wait_timeout: got timeout want halt"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL wait_dr: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL wait_dr: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL wait_extra_dr: got %0d extra want 0", obs_q.size()); end
        n_cmp++; if (cyc !== 85) begin n_bad++; $display("FAIL wait_cycles: got %0d want 85", cyc); end
        n_cmp++; if (addr_moved !== 0) begin n_bad++; $display("FAIL wait_addr_stable: got %0d moves want 0", addr_moved); end
        n_cmp++; if (ret_a !== 32'd17) begin n_bad++; $display("FAIL wait_retired: got %0d want 17", ret_a); end
    endtask

    task automatic test_arith16();
        int cyc; bit tmo; logic [63:0] e, o;
        do_reset();
        prog[0] = limm(1, 16'h7FFF);
        prog[1] = limm(2, 16'h0001);
        prog[2] = rr(8'h14, 3, 1, 2);
        prog[3] = rr(8'h15, 4, 2, 1);
        prog[4] = cpdr(4);
        prog[5] = cpdr(3);
        prog[6] = I_END;
        exp_q.push_back(64'h8002);
        exp_q.push_back(64'h8000);
        run_core(1'b1, 200, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL arith16_timeout: got timeout want halt"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL arith16_dr: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL arith16_dr: got %h want %h", o, e); end end
        end
        n_cmp++; if (ret_b !== 32'd7 || err_b !== 1'b0) begin n_bad++; $display("FAIL arith16_status: got retired=%0d err=%b want 7/0", ret_b, err_b); end
    endtask

    task automatic test_end();
        int cyc, req_hi; bit tmo; logic [63:0] e, o;
        do_reset();
        prog[0] = limm(1, 16'h0001);
        prog[1] = limm(2, 16'h0002);
        prog[2] = rr(8'h14, 3, 1, 2);
        prog[3] = cpdr(3);
        prog[4] = rr(8'h15, 4, 1, 2);
        prog[5] = I_END;
        exp_q.push_back(64'h3);
        run_core(1'b0, 200, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL end_timeout: got timeout want halt"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL end_dr: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL end_dr: got %h want %h", o, e); end end
        end
        n_cmp++; if ({halted_a, err_a} !== 2'b10) begin n_bad++; $display("FAIL end_status: got halted/err=%b want 10", {halted_a, err_a}); end
        n_cmp++; if (pc_a !== 16'd6 || ret_a !== 32'd6) begin n_bad++; $display("FAIL end_count: got pc=%0d retired=%0d want 6/6", pc_a, ret_a); end
        n_cmp++; if (u_a.rf[4] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL end_sub_wrap: got %h want ffffffff", u_a.rf[4]); end
        req_hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run_a = i[0];
            if (ifa.imem_req) req_hi++;
        end
        run_a = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_hi !== 0) begin n_bad++; $display("FAIL end_req_frozen: got %0d req cycles want 0", req_hi); end
        n_cmp++; if (pc_a !== 16'd6 || ret_a !== 32'd6 || dr_a !== 32'd3) begin n_bad++; $display("FAIL end_frozen: got pc=%0d retired=%0d dr=%h want 6/6/3", pc_a, ret_a, dr_a); end
    endtask

    task automatic test_illegal();
        int cyc; bit tmo;
        do_reset();
        prog[0] = limm(1, 16'h0005);
        prog[1] = {8'h77, 6'd1, 18'd0};
        run_core(1'b0, 200, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL illop_timeout: got timeout want halt"); end
        n_cmp++; if ({halted_a, err_a} !== 2'b11) begin n_bad++; $display("FAIL illop_status: got halted/err=%b want 11", {halted_a, err_a}); end
        n_cmp++; if (ret_a !== 32'd1 || pc_a !== 16'd2) begin n_bad++; $display("FAIL illop_count: got retired=%0d pc=%0d want 1/2", ret_a, pc_a); end
        n_cmp++; if (u_a.rf[1] !== 32'd5) begin n_bad++; $display("FAIL illop_dest: got %h want 5", u_a.rf[1]); end

        do_reset();
        prog[0] = limm(1, 16'h0003);
        prog[1] = cpdr(1);
        prog[2] = rr(8'h14, 63, 1, 1);
        run_core(1'b1, 200, cyc, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL illidx_timeout: got timeout want halt"); end
        n_cmp++; if ({halted_b, err_b} !== 2'b11) begin n_bad++; $display("FAIL illidx_status: got halted/err=%b want 11", {halted_b, err_b}); end
        n_cmp++; if (ret_b !== 32'd2 || dr_b !== 16'd3) begin n_bad++; $display("FAIL illidx_count: got retired=%0d dr=%h want 2/3", ret_b, dr_b); end
    endtask

    task automatic test_pc_wrap();
        int cyc; bit tmo, patched; logic [63:0] e, o;
        do_reset();
        prog[0] = cpdr(2);
        prog[1] = limm(3, 16'h0001);
        for (int i = 2; i < 15; i++) prog[i] = limm(3, 16'(i));
        prog[15] = limm(2, 16'h0BEE);
        exp_q.push_back(64'h0BEE);
        patched = 1'b0;
        fork
            run_core(1'b1, 200, cyc, tmo);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (pc_b == 4'd2) begin
                        prog[1] = I_END;
                        patched = 1'b1;
                        break;
                    end
                end
            end
        join
        n_cmp++; if (tmo !== 1'b0 || patched !== 1'b1) begin n_bad++; $display("FAIL wrap_timeout: got tmo=%b patched=%b want 0/1", tmo, patched); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL wrap_dr: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL wrap_dr: got %h want %h", o, e); end end
        end
        n_cmp++; if (pc_b !== 4'd2 || ret_b !== 32'd18) begin n_bad++; $display("FAIL wrap_count: got pc=%0d retired=%0d want 2/18", pc_b, ret_b); end
        n_cmp++; if (cyc !== 36) begin n_bad++; $display("FAIL wrap_cycles: got %0d want 36", cyc); end
    endtask

    task automatic test_reset_mid_fetch();
        bit found; int req_hi;
        do_reset();
        wait_cycles = 10;
        prog[0] = limm(1, 16'h0055);
        prog[1] = cpdr(1);
        prog[2] = limm(2, 16'h0001);
        prog[3] = I_END;
        @(negedge clk);
        run_a = 1'b1;
        @(negedge clk);
        run_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pc_a == 16'd3 && ifa.imem_req) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (found !== 1'b1 || dr_a !== 32'h55) begin n_bad++; $display("FAIL midrst_setup: got found=%b dr=%h want 1/55", found, dr_a); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (ifa.imem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_req: got %b want 0", ifa.imem_req); end
        n_cmp++; if (pc_a !== 16'd0 || dr_a !== 32'd0) begin n_bad++; $display("FAIL midrst_state: got pc=%h dr=%h want 0/0", pc_a, dr_a); end
        @(negedge clk);
        reset = 1'b1;
        req_hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.imem_req) req_hi++;
        end
        n_cmp++; if (req_hi !== 0 || pc_a !== 16'd0) begin n_bad++; $display("FAIL midrst_idle: got req cycles=%0d pc=%0d want 0/0", req_hi, pc_a); end
        run_a = 1'b1;
        @(posedge clk);
        #1;
        run_a = 1'b0;
        n_cmp++; if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 16'd0) begin n_bad++; $display("FAIL midrst_restart: got req=%b addr=%h want 1/0", ifa.imem_req, ifa.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_limm_cpdr();
        test_logic_ops();
        test_wait_states();
        test_arith16();
        test_end();
        test_illegal();
        test_pc_wrap();
        test_reset_mid_fetch();
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/osecpu_core_p.md
# osecpu_core_p

Parametrised OSECPU execution core: the multi-cycle successor of the fixed 32-bit fetch/decode sequencer.
- Fetches 32-bit instructions over a variable-latency req/ack instruction-memory port and executes them against an internal integer register file.
- Drives the debug register (DR) and program counter outputs, and reports halt and error status.
- Sits between the instruction memory and the board-level debug display logic.

## Interface
Parameters:
- DATA_W, 32: integer register and DR width; legal range 16..64.
- NUM_IREG, 64: number of integer registers; legal range 2..64.
- ADDR_W, 16: PC and instruction address width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. All state clears immediately while low.
- run  in  1  start strobe. Sampled only in IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address. Equals pc while imem_req is high.
- imem_ack  in  1  fetch complete. imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dr  out  DATA_W  debug register.
- pc  out  ADDR_W  address of the next instruction to fetch.
- halted  out  1  core stopped (END or error).
- err  out  1  core stopped on an illegal instruction.
- retired  out  32  count of successfully executed instructions.

## Operation
Instruction fields:
- op = [31:24]
- ra = [23:18] (destination)
- rb = [17:12]
- rc = [11:6]
- imm = [15:0], sign-extended to DATA_W

Opcodes:
- 02 LIMM16: R[ra] = sext(imm).
- 10 OR: R[ra] = R[rb] | R[rc].
- 11 XOR: R[ra] = R[rb] ^ R[rc].
- 12 AND: R[ra] = R[rb] & R[rc].
- 14 ADD: R[ra] = R[rb] + R[rc], modulo 2^DATA_W.
- 15 SUB: R[ra] = R[rb] - R[rc], modulo 2^DATA_W.
- 20 CMPE: R[ra] = all-ones if R[rb] == R[rc], else 0.
- D2 CP: R[ra] = R[rb].
- D3 CPDR: dr = R[ra].
- F0 END: stop the core.

Illegal instructions:
- Any other opcode is illegal.
- A register index >= NUM_IREG in any field the opcode reads or writes is illegal.
- An illegal instruction writes nothing, sets err and halted, and does not increment retired.

State machine (IDLE, FETCH, EXEC, HALT):
- IDLE: imem_req = 0. Goes to FETCH when run = 1.
- FETCH: imem_req = 1, imem_addr = pc.
  - On imem_ack: latch imem_rdata into the instruction register, set pc = pc + 1 (wraps modulo 2^ADDR_W), go to EXEC.
  - Without ack: stay in FETCH with req and addr held stable.
- EXEC: perform one register-file write or DR write, increment retired (wraps), go to FETCH.
  - END: retired++, halted = 1, go to HALT.
  - Illegal: go to HALT with err = 1.
- HALT: sticky. imem_req = 0, all outputs frozen, run ignored. Only reset leaves HALT.

Register file:
- NUM_IREG x DATA_W.
- Written only in EXEC.
- Reads are combinational from the latched instruction fields.

## Timing
- Reset values: pc = 0, dr = 0, all registers = 0, retired = 0, halted = 0, err = 0, imem_req = 0, imem_addr = 0, state = IDLE.
- The run edge enters FETCH. imem_req is high in the following cycle.
- With ack in the first req cycle, each instruction takes 2 cycles: FETCH, then EXEC. Each extra ack-wait cycle adds 1 cycle.
- Register write results are visible to the next instruction's EXEC; no forwarding hazards are possible.
- dr updates on the clock edge that ends the CPDR EXEC cycle.
- halted and err assert on the edge that ends EXEC and stay asserted.
- imem_ack is ignored outside FETCH.
- Reset asserted mid-FETCH drops imem_req asynchronously, discards the pending fetch, and returns to IDLE.
- pc = 2^ADDR_W - 1 fetches normally, then wraps to 0.
- ra == rb, or ra == rc, reads the old value and writes the new one.

## Test plan
- Load LIMM16 r1,0x8000 and CPDR r1 with ack on the first cycle (DATA_W = 32) -> dr = 0xFFFF8000 after 4 cycles of execution, retired = 2.
- LIMM16 r1,0x7FFF; LIMM16 r2,1; ADD r3,r1,r2; SUB r4,r2,r1; CPDR r4 with DATA_W = 16 -> dr = 0x8002, and R3 = 0x8000 checked via CPDR r3.
- END at address 5 -> halted = 1, err = 0, pc = 6, retired = 6, imem_req stays 0 while run pulses are applied.
- Opcode 0x77, or ADD r63 with NUM_IREG = 8 -> halted = 1, err = 1, destination unchanged, retired not incremented.
- ack delayed 3 cycles per fetch -> imem_req and imem_addr stable throughout the wait, each instruction takes 5 cycles, and results are identical to the zero-wait run.
- Drop reset while in FETCH at pc = 3 -> imem_req = 0 immediately, pc = 0, dr = 0. After reset release, the core waits in IDLE until run.
